// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: width derivation and handshake constants.
package fifo_pkg;

    localparam logic HS_ON  = 1'b1;
    localparam logic HS_OFF = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Pointer width: indexes 0..depth-1.
    function automatic int aw_of(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Count width: must hold 0..depth inclusive.
    function automatic int cw_of(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; clr takes priority over inc, rst over both.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr)
            ptr_d = '0;
        else if (inc)
            ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock show-ahead ready/valid FIFO, any depth >= 2, with level and thresholds.
// Define FIFO_WATERMARK_EN to add the max_level peak-occupancy port.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH    = 8,
    parameter  int FIFO_DEPTH    = 255,
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter  int AEMPTY_THRESH = 1,
    localparam int AW            = aw_of(FIFO_DEPTH),
    localparam int CW            = cw_of(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [FIFO_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [FIFO_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         level,
    output logic                  almost_full,
`ifdef FIFO_WATERMARK_EN
    output logic                  almost_empty,
    output logic [CW-1:0]         max_level
`else
    output logic                  almost_empty
`endif
);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_inc;
    logic [CW-1:0]         level_q, level_d;
    logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  afull_q, afull_d, aempty_q, aempty_d;
    logic                  push, pop;

    assign wr_ready = (level_q != CW'(FIFO_DEPTH));
    assign rd_valid = (level_q != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
        .clk(clk), .rst(rst), .clr(flush), .inc(push), .ptr(wr_ptr)
    );
    fifo_wrap_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
        .clk(clk), .rst(rst), .clr(flush), .inc(pop), .ptr(rd_ptr)
    );

    assign rd_ptr_inc = (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);

    // The head lives in the array and is mirrored into rd_data_q one edge
    // early, so capacity stays exactly FIFO_DEPTH with no read bubble.
    always_comb begin
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (flush) begin
            level_d   = '0;
            rd_data_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_d = level_q + CW'(1);
                2'b01:   level_d = level_q - CW'(1);
                default: level_d = level_q;
            endcase
            if (pop) begin
                if (level_q == CW'(1))
                    rd_data_d = push ? wr_data : rd_data_q;
                else
                    rd_data_d = mem_q[rd_ptr_inc];
            end else if (!rd_valid && push) begin
                rd_data_d = wr_data;
            end
        end
        afull_d  = (int'(level_d) >= AFULL_THRESH);
        aempty_d = (int'(level_d) <= AEMPTY_THRESH);
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst)
            mem_q[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            rd_data_q <= '0;
            afull_q   <= (AFULL_THRESH == 0) ? HS_ON : HS_OFF;
            aempty_q  <= (AEMPTY_THRESH >= 0) ? HS_ON : HS_OFF;
        end else begin
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
        end
    end

    assign level        = level_q;
    assign rd_data      = rd_data_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;

`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] max_level_q, max_level_d;

    // Flush empties the FIFO but the peak is history, so only rst clears it.
    always_comb begin
        max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) max_level_q <= '0;
        else     max_level_q <= max_level_d;
    end

    assign max_level = max_level_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed + random bench for sync_fifo_flex (DEPTH=5) against a queue model.
module tb_sync_fifo_flex;

    localparam int DEPTH = 5;
    localparam int W     = 8;
    localparam int CW    = 3;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst, flush, wr_valid, rd_ready;
    logic          wr_ready, rd_valid, almost_full, almost_empty;
    logic [W-1:0]  wr_data, rd_data;
    logic [CW-1:0] level;
`ifdef FIFO_WATERMARK_EN
    logic [CW-1:0] max_level;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    int           mmax = 0;
    int           popped = 0;
    int           pushed = 0;
    int           peak_stream = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level), .almost_full(almost_full),
`ifdef FIFO_WATERMARK_EN
        .almost_empty(almost_empty), .max_level(max_level)
`else
        .almost_empty(almost_empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string ph);
        int n;
        n = mq.size();
        chk({ph, ".level"},    32'(level),        32'(n));
        chk({ph, ".wr_ready"}, 32'(wr_ready),     32'(n != DEPTH));
        chk({ph, ".rd_valid"}, 32'(rd_valid),     32'(n != 0));
        chk({ph, ".afull"},    32'(almost_full),  32'(n >= AF));
        chk({ph, ".aempty"},   32'(almost_empty), 32'(n <= AE));
        if (n != 0) chk({ph, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
`ifdef FIFO_WATERMARK_EN
        chk({ph, ".max_level"}, 32'(max_level), 32'(mmax));
`endif
    endtask

    // Apply one cycle of inputs, advance the model from the pre-edge state, then check.
    task automatic step(input logic wv, input logic [W-1:0] wd, input logic rr,
                        input logic fl, input logic rs, input string ph);
        bit do_push, do_pop;
        wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl; rst = rs;
        do_push = wv && (mq.size() < DEPTH);
        do_pop  = rr && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            mmax = 0;
        end else begin
            if (fl) begin
                mq.delete();
            end else begin
                if (do_pop) begin
                    void'(mq.pop_front());
                    popped++;
                end
                if (do_push) begin
                    mq.push_back(wd);
                    pushed++;
                end
            end
            if (mq.size() > mmax) mmax = mq.size();
        end
        check_outs(ph);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;

        step(0, 8'h00, 0, 0, 1, "reset");
        step(0, 8'h00, 0, 0, 1, "reset");
        chk("reset.rd_data", 32'(rd_data), 32'h0);

        // Fill to capacity, then offer a sixth word under backpressure.
        for (int i = 0; i < DEPTH; i++) step(1, 8'hA1 + 8'(i), 0, 0, 0, "fill");
        chk("full.level", 32'(level), 32'd5);
        step(1, 8'hA6, 0, 0, 0, "full_bp");
        chk("full_bp.head", 32'(rd_data), 32'hA1);

        // Pop while full with a write offered: write must be refused this edge.
        wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
        #1;
        chk("full.wr_ready_no_comb_path", 32'(wr_ready), 32'd0);
        step(1, 8'hEE, 1, 0, 0, "full_pop");
        chk("full_pop.level", 32'(level), 32'd4);
        chk("full_pop.wr_ready", 32'(wr_ready), 32'd1);

        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0, "drain");

        // Show-ahead: word visible the cycle after the push.
        step(1, 8'h3C, 0, 0, 0, "single");
        chk("single.rd_data", 32'(rd_data), 32'h3C);
        step(0, 8'h00, 1, 0, 0, "single_pop");

        // Streaming through several pointer wraps.
        popped = 0; pushed = 0; peak_stream = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 8'($urandom), 1, 0, 0, "stream");
            if (int'(level) > peak_stream) peak_stream = int'(level);
        end
        step(0, 8'h00, 1, 0, 0, "stream_tail");
        chk("stream.peak_le2", 32'(peak_stream <= 2), 32'd1);
        chk("stream.pushed", 32'(pushed), 32'd20);
        chk("stream.popped", 32'(popped), 32'd20);

        // Flush wins over a simultaneous push and pop.
        for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 0, 0, "pre_flush");
        step(1, 8'h99, 1, 1, 0, "flush");
        chk("flush.level", 32'(level), 32'd0);
        step(1, 8'h55, 0, 0, 0, "post_flush");
        chk("post_flush.rd_data", 32'(rd_data), 32'h55);
        step(0, 8'h00, 1, 0, 0, "post_flush_pop");

        // Peak tracking across drain and flush, cleared by reset.
        step(0, 8'h00, 0, 0, 1, "wm_rst");
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, 0, "wm_fill");
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0, "wm_drain");
        step(0, 8'h00, 0, 1, 0, "wm_flush");
        step(0, 8'h00, 0, 0, 1, "wm_rst2");

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 149) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised single-clock ready/valid FIFO. Next generation of the team's basic FIFO.
- Generalised over width and arbitrary (non-power-of-two) depth.
- Adds an occupancy count, parameterised almost-full/almost-empty thresholds, and a synchronous flush.
- Sits between pipeline stages and bus front-ends inside one clock domain.

Parameters:
- FIFO_WIDTH, 8, data bits per entry.
- FIFO_DEPTH, 255, total entries; any value >= 2, not restricted to a power of two.
- AFULL_THRESH, FIFO_DEPTH-1, almost_full asserts when level >= this value.
- AEMPTY_THRESH, 1, almost_empty asserts when level <= this value.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; does not reset the watermark.
- wr_valid  in  1  producer offers wr_data.
- wr_ready  out  1  FIFO can accept.
- wr_data  in  FIFO_WIDTH  write data.
- rd_valid  out  1  rd_data holds the head entry.
- rd_ready  in  1  consumer accepts the head.
- rd_data  out  FIFO_WIDTH  head entry; registered.
- level  out  CW  current occupancy, 0..FIFO_DEPTH.
- almost_full  out  1  level >= AFULL_THRESH.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- max_level  out  CW  peak occupancy; present only with FIFO_WATERMARK_EN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Widths: AW = clog2(FIFO_DEPTH) for pointers; CW = clog2(FIFO_DEPTH+1) for level.
- Push and pop:
  - push = wr_valid & wr_ready.
  - pop = rd_valid & rd_ready.
  - Both are evaluated on the same edge.
- Reset values:
  - rd/wr pointers = 0, level = 0, rd_valid = 0, rd_data = 0.
  - wr_ready = 1, almost_empty = 1 (0 <= AEMPTY_THRESH).
  - almost_full = 0 unless AFULL_THRESH == 0.
  - max_level = 0.
- Output timing:
  - wr_ready = (level != FIFO_DEPTH). Decoded from registered state only; no combinational path from rd_ready.
  - rd_valid = (level != 0). level, rd_data, almost_full and almost_empty are all registered.
- Latency: a push into an empty FIFO at edge N gives rd_valid=1 with rd_data = that word in cycle N+1.
  - This is show-ahead (first-word fall-through); there is no read-enable bubble.
- Capacity: exactly FIFO_DEPTH entries, whether the head is held in an output register or read from the array.
- Pointer wrap: each pointer increments modulo FIFO_DEPTH (DEPTH-1 -> 0). No reliance on power-of-two overflow.
- Level update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push+pop or on neither.
- Full FIFO: wr_ready=0. A simultaneous pop frees one slot, and wr_ready returns to 1 the next cycle.
- Empty FIFO: rd_valid=0, so a pop cannot occur. A push is stored and presented next cycle; there is no same-cycle bypass.
- Simultaneous push+pop with level==1: the new word becomes the head next cycle and level stays 1.
- Data ordering: strict FIFO order. rd_data holds stable while rd_valid=1 and rd_ready=0.
- Backpressure: wr_valid with wr_ready=0 is normal backpressure, not an error. wr_data is ignored.
- Flush:
  - On the next edge: pointers = 0, level = 0, rd_valid = 0.
  - Any push or pop in the same cycle is discarded.
- Priority: rst > flush > push/pop.
- Reset mid-operation: same priority as above; all state returns to reset values on the next edge and partial contents are lost.
- Threshold flags are recomputed from the next-state level, so they align with level every cycle.

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- Defined:
  - Adds a max_level port and register.
  - Each edge, max_level <= max(max_level, next level).
  - Cleared only by rst, not by flush.
- Undefined:
  - No max_level port and no extra registers.
  - All other behaviour is identical.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function.
  - Width-derivation helpers for AW and CW.
  - Common ready/valid handshake constants.
- Sub-module fifo_wrap_ptr:
  - Parameter DEPTH.
  - Inputs clk, rst, clr, inc.
  - Output ptr[AW-1:0], modulo-DEPTH increment.
  - Instantiated twice (read and write).

Test Plan:
- DEPTH=5: push 5 words 0xA1..0xA5 with rd_ready=0 -> level=5, wr_ready=0, almost_full=1; a 6th wr_valid is not accepted.
- DEPTH=5: continuous push and pop of 20 words over several wraps -> output order exact; level never exceeds 2; no lost or duplicated words.
- Empty FIFO, single push of 0x3C at edge N -> rd_valid=1, rd_data=0x3C in cycle N+1; level=1.
- Full FIFO with pop and wr_valid in the same cycle -> push rejected, level=4, wr_ready=1 next cycle.
- Level=3, assert flush together with a push and a pop -> next cycle level=0, rd_valid=0, wr_ready=1; a subsequent push of 0x55 reads back 0x55.
- FIFO_WATERMARK_EN: fill to 4, drain to 0, flush -> max_level=4 throughout; after rst, max_level=0.
